multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main sequencing controller for the multi-cycle CPU. A Moore-style FSM with memory-ready qualification decodes OpCode/Funct from the instruction register. It steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, including the 4-bit ALUOp consumed by the ALU control decoder, so it decides when and how the single shared ALU is used in each cycle.

## Interface
Parameters:
- `STATE_W`, 4, state register width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `OpCode`  in  6  IR[31:26].
- `Funct`  in  6  IR[5:0].
- `mem_ready`  in  1  memory completes access this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load if ALU Zero.
- `IorD`  out  1  0 = PC address, 1 = ALUOut address.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  2  0 ALUOut, 1 MDR, 2 PC (link).
- `RegDst`  out  2  0 rt, 1 rd, 2 $31.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  2  0 PC, 1 rs, 2 shamt.
- `ALUSrcB`  out  2  0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2.
- `ALUOp`  out  4  0 add, 1 beq, 2 R-type, 3 addiu, 4 andi, 5 slti, 6 sltiu.
- `PCSource`  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 rs (jr/jalr).
- `ExtOp`  out  1  1 sign-extend, 0 zero-extend.
- `LuiOp`  out  1  imm<<16 select.
- `instr_retired`  out  32  present only with macro; see Configuration.

## Operation
- States: IDLE, IF, ID, EX_R, EX_I, EX_ADDR, EX_BR, EX_J, MEM_RD, MEM_WR, WB_R, WB_I, WB_LD.
- Reset: state=IDLE. All outputs are 0, ALUOp=0.
- IDLE→IF unconditionally on the first clock after reset release.
- IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite and PCWrite assert only when mem_ready=1.
  - Hold in IF while mem_ready=0.
- ID: ALUSrcA=0, ALUSrcB=3, ALUOp=0, ExtOp=1, so the branch target is placed in ALUOut. Dispatch:
  - 0x00 with jr(0x08)/jalr(0x09)→EX_J.
  - Other 0x00→EX_R.
  - 0x23/0x2b→EX_ADDR.
  - 0x04→EX_BR.
  - 0x02/0x03→EX_J.
  - 0x08,0x09,0x0c,0x0a,0x0b,0x0f→EX_I.
  - Any other opcode→IF (treated as nop).
- EX_R: ALUOp=2, ALUSrcB=0. ALUSrcA=2 when Funct∈{0x00,0x02,0x03}, else 1. Next state WB_R.
- EX_I: ALUSrcA=1, ALUSrcB=2. ExtOp=0 for andi (0x0c), else 1. LuiOp=1 for 0x0f. ALUOp by opcode:
  - addi/addiu/lui → 0 for addi and lui, 3 for addiu.
  - andi → 4.
  - slti → 5.
  - sltiu → 6.
  - Next state WB_I.
- EX_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0, ExtOp=1. Next state MEM_RD for lw, MEM_WR for sw.
- EX_BR: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Next state IF.
- EX_J: PCWrite=1.
  - PCSource=2 for j/jal, 3 for jr/jalr.
  - jal and jalr also assert RegWrite=1 and MemtoReg=2. RegDst=2 for jal; RegDst=1 for jalr.
  - Next state IF.
- MEM_RD: MemRead=1, IorD=1. Move to WB_LD on mem_ready, otherwise hold.
- MEM_WR: IorD=1. MemWrite=1 only in the cycle mem_ready=1. Then move to IF.
- WB_R: RegWrite=1 (except jr), RegDst=1, MemtoReg=0. Next state IF.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0. Next state IF.
- WB_LD: RegWrite=1, RegDst=0, MemtoReg=1. Next state IF.
- Any signal not listed for a state is 0 in that state.

## Timing
- Latency with mem_ready tied high, counted from IF entry to the next IF entry:
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr, jalr: 3 cycles.
  - Unknown opcode: 2 cycles.
- Each cycle mem_ready=0 in IF, MEM_RD or MEM_WR adds exactly one cycle. No output changes during these stall cycles.
- The control outputs are combinational from the state and mem_ready, with no register stage.
- Reset asserted mid-instruction forces IDLE and zero outputs immediately (asynchronous). Any in-flight write is abandoned.
- OpCode and Funct are sampled only in ID and EX. Changes to them in other states are ignored.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined:
  - `instr_retired` is a 32-bit counter, reset to 0.
  - It increments by 1 on every transition into IF from any state other than IDLE, and wraps at 2^32.
- Macro undefined: the port and counter are absent. FSM behaviour is identical in both builds.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state enumeration;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI);
  - funct constants (FN_JR, FN_JALR, FN_SLL, FN_SRL, FN_SRA);
  - ALUOp encodings 0–6, matching the ALU control decoder.
- One sub-module, `multicycle_ctrl_decode`: a combinational map from state, OpCode, Funct and mem_ready to all control outputs. The top module holds only the state register and the optional counter.

## Test plan
- Reset low then released, mem_ready=1 → one cycle IDLE with all outputs 0. Next cycle is IF with MemRead=1, IRWrite=1, PCWrite=1, ALUOp=0.
- add (OpCode 0x00, Funct 0x20) → IF, ID, EX_R with ALUOp=2, WB_R with RegWrite=1 and RegDst=1, then IF. Four cycles total.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD → 7 cycles total. RegWrite=1 and MemtoReg=1 exactly once.
- beq (0x04) → EX_BR has PCWriteCond=1, ALUOp=1, PCSource=1. RegWrite=0 throughout. 3 cycles.
- jal (0x03) → EX_J has PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2. Opcode 0x3f → return to IF after ID with no write strobes.
- sw (0x2b), reset pulsed low in MEM_WR → MemWrite=0 immediately and state IDLE. With the macro defined, the counter reads 0 after reset and 3 after three complete instructions.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle CPU controller: FSM state encoding,
// MIPS opcode/funct constants and the ALUOp encodings understood by the ALU
// control decoder.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE    = 4'd0,
    S_IF      = 4'd1,
    S_ID      = 4'd2,
    S_EX_R    = 4'd3,
    S_EX_I    = 4'd4,
    S_EX_ADDR = 4'd5,
    S_EX_BR   = 4'd6,
    S_EX_J    = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_WB_R    = 4'd10,
    S_WB_I    = 4'd11,
    S_WB_LD   = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct codes (IR[5:0]) for R-type
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // ALUOp encodings consumed by the ALU control decoder
  localparam logic [3:0] ALUOP_ADD   = 4'd0;
  localparam logic [3:0] ALUOP_BEQ   = 4'd1;
  localparam logic [3:0] ALUOP_RTYPE = 4'd2;
  localparam logic [3:0] ALUOP_ADDIU = 4'd3;
  localparam logic [3:0] ALUOP_ANDI  = 4'd4;
  localparam logic [3:0] ALUOP_SLTI  = 4'd5;
  localparam logic [3:0] ALUOP_SLTIU = 4'd6;

  // R-type register jumps (jr/jalr) are dispatched to the jump state.
  function automatic logic is_reg_jump(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && ((fn == FN_JR) || (fn == FN_JALR));
  endfunction

  // Shift-by-shamt R-type ops take ALU operand A from the shamt field.
  function automatic logic is_shamt_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_decode
// Purely combinational map from the current FSM state, OpCode, Funct and
// mem_ready to the next state and to every datapath control signal.
// Ports:
//   state       in   current FSM state
//   OpCode      in   IR[31:26]
//   Funct       in   IR[5:0]
//   mem_ready   in   memory completes access this cycle
//   next_state  out  FSM next state
//   PCWrite .. LuiOp  out  datapath enables / mux selects / ALUOp
// ----------------------------------------------------------------------------
module multicycle_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        mem_ready,
  output state_t      next_state,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        ExtOp,
  output logic        LuiOp
);

  // Next-state logic: instruction dispatch and memory-ready holds.
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: next_state = S_IF;
      S_IF: begin
        if (mem_ready) next_state = S_ID;
        else           next_state = S_IF;
      end
      S_ID: begin
        case (OpCode)
          OP_RTYPE: begin
            if (is_reg_jump(OpCode, Funct)) next_state = S_EX_J;
            else                            next_state = S_EX_R;
          end
          OP_LW, OP_SW:  next_state = S_EX_ADDR;
          OP_BEQ:        next_state = S_EX_BR;
          OP_J, OP_JAL:  next_state = S_EX_J;
          OP_ADDI, OP_ADDIU, OP_ANDI,
          OP_SLTI, OP_SLTIU, OP_LUI: next_state = S_EX_I;
          default:       next_state = S_IF;  // unknown opcode retires as a nop
        endcase
      end
      S_EX_R:    next_state = S_WB_R;
      S_EX_I:    next_state = S_WB_I;
      S_EX_ADDR: begin
        if (OpCode == OP_LW) next_state = S_MEM_RD;
        else                 next_state = S_MEM_WR;
      end
      S_EX_BR:   next_state = S_IF;
      S_EX_J:    next_state = S_IF;
      S_MEM_RD: begin
        if (mem_ready) next_state = S_WB_LD;
        else           next_state = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) next_state = S_IF;
        else           next_state = S_MEM_WR;
      end
      S_WB_R:  next_state = S_IF;
      S_WB_I:  next_state = S_IF;
      S_WB_LD: next_state = S_IF;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: every control defaults to 0 and is raised per state.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'd0;
    RegDst      = 2'd0;
    RegWrite    = 1'b0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALUOp       = ALUOP_ADD;
    PCSource    = 2'd0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    case (state)
      S_IDLE: begin
        PCWrite = 1'b0;
      end
      S_IF: begin
        // PC + 4 computed every IF cycle; committed only when memory answers.
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'd3;
        ExtOp   = 1'b1;
      end
      S_EX_R: begin
        ALUOp = ALUOP_RTYPE;
        if (is_shamt_shift(Funct)) ALUSrcA = 2'd2;
        else                       ALUSrcA = 2'd1;
      end
      S_EX_I: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ExtOp   = 1'b1;
        case (OpCode)
          OP_ADDIU: ALUOp = ALUOP_ADDIU;
          OP_ANDI: begin
            ALUOp = ALUOP_ANDI;
            ExtOp = 1'b0;
          end
          OP_SLTI:  ALUOp = ALUOP_SLTI;
          OP_SLTIU: ALUOp = ALUOP_SLTIU;
          OP_LUI: begin
            ALUOp = ALUOP_ADD;
            LuiOp = 1'b1;
          end
          default:  ALUOp = ALUOP_ADD;  // addi
        endcase
      end
      S_EX_ADDR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ExtOp   = 1'b1;
      end
      S_EX_BR: begin
        ALUSrcA     = 2'd1;
        ALUOp       = ALUOP_BEQ;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      S_EX_J: begin
        PCWrite = 1'b1;
        if (OpCode == OP_RTYPE) PCSource = 2'd3;
        else                    PCSource = 2'd2;
        // Link writes the return address (current PC) to the register file.
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          MemtoReg = 2'd2;
          RegDst   = 2'd2;
        end else if ((OpCode == OP_RTYPE) && (Funct == FN_JALR)) begin
          RegWrite = 1'b1;
          MemtoReg = 2'd2;
          RegDst   = 2'd1;
        end else begin
          RegWrite = 1'b0;
        end
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = mem_ready;
      end
      S_WB_R: begin
        // jr never reaches this state, so the write is unconditional here.
        RegWrite = 1'b1;
        RegDst   = 2'd1;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Main sequencing controller of the multi-cycle CPU. Holds the FSM state
// register (and optionally a retired-instruction counter); all control
// outputs are combinational from state, OpCode/Funct and mem_ready.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds instr_retired.
// Ports:
//   clk, reset (async, active-low)
//   OpCode, Funct, mem_ready        inputs
//   PCWrite .. LuiOp                datapath controls
//   instr_retired [31:0]            retired count (macro builds only)
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        ExtOp,
  output logic        LuiOp
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instr_retired
`endif
);

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             next_state;

  assign state = state_t'(state_q);

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= STATE_W'(S_IDLE);
    else        state_q <= STATE_W'(next_state);
  end

  multicycle_ctrl_decode u_decode (
    .state       (state),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .mem_ready   (mem_ready),
    .next_state  (next_state),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .ExtOp       (ExtOp),
    .LuiOp       (LuiOp)
  );

`ifdef MULTICYCLE_CTRL_PERF_EN
  // Count instruction completions: entries into IF from a real instruction
  // state (not from IDLE, and not IF holding on a memory stall).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_retired <= 32'd0;
    end else if ((next_state == S_IF) && (state != S_IF) && (state != S_IDLE)) begin
      instr_retired <= instr_retired + 32'd1;
    end else begin
      instr_retired <= instr_retired;
    end
  end
`endif

endmodule
